keypad_encoder: RTL and testbench

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

---
 rtl/keypad_encoder.sv | 209 ++++++++++++++++++++
 tb/tb_keypad_encoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner and encoder: column scan, 2-flop row synchronizer,
// press/release debounce, one-cycle key_valid with a single key-class pulse.
module keypad_encoder #(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       numero_en,
  output logic       operando_key,
  output logic       igual_key,
  output logic       clear_key
);

  // One counter serves both the column dwell and the debounce windows.
  localparam int unsigned CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_SCAN     = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_PRESSED  = 3'd2,
    S_HOLD     = 3'd3,
    S_RELEASE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       col_n_q, col_n_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             numero_q, numero_d;
  logic             operando_q, operando_d;
  logic             igual_q, igual_d;
  logic             clear_q, clear_d;
  logic [3:0]       rows_s;
  logic [3:0]       code_c;

  assign rows_s = sync2_q;

  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // Lowest-index active-low row wins when several are low at the sample point.
  function automatic logic [1:0] lowest_row(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

  assign code_c = map_key(row_q, col_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    numero_d    = 1'b0;
    operando_d  = 1'b0;
    igual_d     = 1'b0;
    clear_d     = 1'b0;

    case (state_q)
      S_SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (!(&rows_s)) begin
            row_d   = lowest_row(rows_s);
            state_d = S_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Only the latched row matters here; other rows are ignored.
      S_DEBOUNCE: begin
        if (!rows_s[row_q]) begin
          if (cnt_q == DEB_LAST) begin
            cnt_d       = '0;
            state_d     = S_PRESSED;
            key_code_d  = code_c;
            key_valid_d = 1'b1;
            numero_d    = (code_c <= 4'h9);
            operando_d  = (code_c >= 4'hA) && (code_c <= 4'hD);
            igual_d     = (code_c == 4'hF);
            clear_d     = (code_c == 4'hE);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d   = '0;
          col_d   = col_q + 2'd1;
          state_d = S_SCAN;
        end
      end

      S_PRESSED: begin
        cnt_d   = '0;
        state_d = S_HOLD;
      end

      S_HOLD: begin
        if (&rows_s) begin
          cnt_d   = '0;
          state_d = S_RELEASE;
        end
      end

      S_RELEASE: begin
        if (&rows_s) begin
          if (cnt_q == DEB_LAST) begin
            cnt_d   = '0;
            col_d   = col_q + 2'd1;
            state_d = S_SCAN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_SCAN;
      end
    endcase

    col_n_d = ~(4'b0001 << col_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_SCAN;
      sync1_q     <= 4'b1111;
      sync2_q     <= 4'b1111;
      cnt_q       <= '0;
      col_q       <= 2'd0;
      col_n_q     <= 4'b1110;
      row_q       <= 2'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      numero_q    <= 1'b0;
      operando_q  <= 1'b0;
      igual_q     <= 1'b0;
      clear_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= row_n;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      col_n_q     <= col_n_d;
      row_q       <= row_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      numero_q    <= numero_d;
      operando_q  <= operando_d;
      igual_q     <= igual_d;
      clear_q     <= clear_d;
    end
  end

  assign col_n        = col_n_q;
  assign key_code     = key_code_q;
  assign key_valid    = key_valid_q;
  assign numero_en    = numero_q;
  assign operando_key = operando_q;
  assign igual_key    = igual_q;
  assign clear_key    = clear_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: a matrix model pulls a row low while its key's column is driven.
module tb_keypad_encoder;

  localparam int unsigned SD = 4;
  localparam int unsigned DB = 8;

  logic       clk;
  logic       reset;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid, numero_en, operando_key, igual_key, clear_key;

  logic       key_active;
  logic [1:0] key_row, key_col;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;
  int excl_err = 0;
  logic [3:0] last_code = 4'h0;
  logic [3:0] last_cls  = 4'h0;

  typedef struct {
    logic [1:0] row;
    logic [1:0] col;
    logic [3:0] code;
    logic [3:0] cls;   // {numero, operando, igual, clear}
  } vec_t;

  vec_t vecs[8];

  keypad_encoder #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk          (clk),
    .reset        (reset),
    .row_n        (row_n),
    .col_n        (col_n),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .numero_en    (numero_en),
    .operando_key (operando_key),
    .igual_key    (igual_key),
    .clear_key    (clear_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row_n = 4'hF;
    if (key_active && (col_n[key_col] == 1'b0)) row_n[key_row] = 1'b0;
  end

  function automatic logic [3:0] cls_of(input logic [3:0] code);
    if (code <= 4'h9)       return 4'b1000;
    else if (code <= 4'hD)  return 4'b0100;
    else if (code == 4'hF)  return 4'b0010;
    else                    return 4'b0001;
  endfunction

  // Pulse monitor: count key_valid, record code/class, flag stray or mixed class pulses.
  always @(posedge clk) begin
    #1;
    if (key_valid) begin
      pulses++;
      last_code = key_code;
      last_cls  = {numero_en, operando_key, igual_key, clear_key};
      if (last_cls !== cls_of(key_code)) excl_err++;
    end else if ({numero_en, operando_key, igual_key, clear_key} != 4'b0000) begin
      excl_err++;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_pulse(input int base, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (pulses != base) begin
        seen = 1'b1;
        break;
      end
    end
    check(nm, int'(seen), 1);
  endtask

  task automatic wait_col(input logic [3:0] target, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (col_n == target) begin
        seen = 1'b1;
        break;
      end
    end
    check(nm, int'(seen), 1);
  endtask

  initial begin
    int p0;
    logic [3:0] exp_col;

    vecs[0] = '{2'd1, 2'd1, 4'h5, 4'b1000};
    vecs[1] = '{2'd3, 2'd2, 4'hF, 4'b0010};
    vecs[2] = '{2'd1, 2'd3, 4'hB, 4'b0100};
    vecs[3] = '{2'd3, 2'd0, 4'hE, 4'b0001};
    vecs[4] = '{2'd3, 2'd1, 4'h0, 4'b1000};
    vecs[5] = '{2'd3, 2'd3, 4'hD, 4'b0100};
    vecs[6] = '{2'd0, 2'd0, 4'h1, 4'b1000};
    vecs[7] = '{2'd2, 2'd2, 4'h9, 4'b1000};

    key_active = 1'b0;
    key_row    = 2'd0;
    key_col    = 2'd0;
    reset      = 1'b1;
    repeat (3) @(negedge clk);

    check("reset_col_n", int'(col_n), 4'b1110);
    check("reset_key_code", int'(key_code), 0);
    check("reset_pulses", int'({key_valid, numero_en, operando_key, igual_key, clear_key}), 0);
    reset = 1'b0;

    // Idle scan: column advances every SD cycles and wraps.
    for (int k = 1; k <= 4; k++) begin
      repeat (SD) @(negedge clk);
      exp_col = ~(4'b0001 << (k % 4));
      check($sformatf("idle_col_%0d", k), int'(col_n), int'(exp_col));
    end
    check("idle_no_pulse", pulses, 0);

    foreach (vecs[i]) begin
      p0         = pulses;
      key_row    = vecs[i].row;
      key_col    = vecs[i].col;
      key_active = 1'b1;
      wait_pulse(p0, $sformatf("v%0d_pulse_seen", i));
      repeat (50) @(negedge clk);
      exp_col = ~(4'b0001 << vecs[i].col);
      check($sformatf("v%0d_pulse_count", i), pulses - p0, 1);
      check($sformatf("v%0d_code", i), int'(last_code), int'(vecs[i].code));
      check($sformatf("v%0d_class", i), int'(last_cls), int'(vecs[i].cls));
      check($sformatf("v%0d_col_frozen", i), int'(col_n), int'(exp_col));
      check($sformatf("v%0d_code_held", i), int'(key_code), int'(vecs[i].code));
      key_active = 1'b0;
      repeat (30) @(negedge clk);
    end

    // Bounce on '5': low long enough to enter debounce, then released early.
    key_row = 2'd1;
    key_col = 2'd1;
    wait_col(4'b1110, "bounce_sync0");
    wait_col(4'b1101, "bounce_sync1");
    p0 = pulses;
    key_active = 1'b1;
    repeat (5) @(negedge clk);
    key_active = 1'b0;
    repeat (2) @(negedge clk);
    check("bounce_col_frozen", int'(col_n), 4'b1101);
    repeat (2) @(negedge clk);
    check("bounce_next_col", int'(col_n), 4'b1011);
    check("bounce_no_pulse", pulses - p0, 0);
    repeat (30) @(negedge clk);

    // Hold '7', glitch during release debounce, then press again.
    key_row = 2'd2;
    key_col = 2'd0;
    p0 = pulses;
    key_active = 1'b1;
    wait_pulse(p0, "seven_first_seen");
    repeat (20) @(negedge clk);
    check("seven_first_code", int'(last_code), 4'h7);
    key_active = 1'b0;
    repeat (5) @(negedge clk);
    key_active = 1'b1;
    repeat (2) @(negedge clk);
    key_active = 1'b0;
    repeat (8) @(negedge clk);
    check("release_restart_col", int'(col_n), 4'b1110);
    check("release_glitch_no_pulse", pulses - p0, 1);
    repeat (30) @(negedge clk);
    key_active = 1'b1;
    wait_pulse(p0 + 1, "seven_second_seen");
    repeat (10) @(negedge clk);
    check("seven_second_code", int'(last_code), 4'h7);
    check("seven_total_pulses", pulses - p0, 2);
    key_active = 1'b0;
    repeat (30) @(negedge clk);

    // Reset mid-debounce of '9', key held through reset deassertion.
    key_row = 2'd2;
    key_col = 2'd2;
    wait_col(4'b1101, "rst_sync1");
    wait_col(4'b1011, "rst_sync2");
    p0 = pulses;
    key_active = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_col_frozen", int'(col_n), 4'b1011);
    reset = 1'b1;
    @(negedge clk);
    check("rst_col_n", int'(col_n), 4'b1110);
    check("rst_key_code", int'(key_code), 0);
    check("rst_outputs", int'({key_valid, numero_en, operando_key, igual_key, clear_key}), 0);
    check("rst_no_pulse", pulses - p0, 0);
    reset = 1'b0;
    wait_pulse(p0, "rst_fresh_press_seen");
    repeat (5) @(negedge clk);
    check("rst_fresh_press_code", int'(last_code), 4'h9);
    check("rst_fresh_press_count", pulses - p0, 1);
    key_active = 1'b0;
    repeat (30) @(negedge clk);

    check("class_exclusivity", excl_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
